// File: rtl/am_tx_pkg.sv
// Shared constants and the BIP fold helper for the transmit alignment-marker path.
package am_tx_pkg;

    localparam int AM_LANE_N  = 4;
    localparam int AM_BLOCK_W = 66;

    localparam logic [1:0] SYNC_CTRL = 2'b01;
    localparam logic [1:0] SYNC_DATA = 2'b10;

    // M0/M1/M2 per lane, lane 0 first
    localparam logic [7:0] AM_M [0:3][0:2] = '{
        '{8'h90, 8'h76, 8'h47},
        '{8'hF0, 8'hC4, 8'hE6},
        '{8'hC5, 8'h65, 8'h9B},
        '{8'hA2, 8'h79, 8'h3D}
    };

    typedef enum logic {
        ST_AM   = 1'b0,
        ST_DATA = 1'b1
    } am_state_e;

    // Payload bit j lands on BIP bit (j-2)%8; sync bits 0/1 land on BIP bits 3/4.
    function automatic logic [7:0] bip_fold(input logic [AM_BLOCK_W-1:0] blk);
        logic [7:0] r;
        r = '0;
        for (int j = 2; j < AM_BLOCK_W; j++) begin
            r[3'((j - 2) % 8)] ^= blk[j];
        end
        r[3] ^= blk[0];
        r[4] ^= blk[1];
        return r;
    endfunction

endpackage

// File: rtl/am_bip_lane_tx.sv
// Per-lane BIP accumulator and alignment-marker block builder.
module am_bip_lane_tx
    import am_tx_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [AM_BLOCK_W-1:0] block_i,
    input  logic                  fold_i,
    input  logic                  load_i,
    output logic [AM_BLOCK_W-1:0] marker_o
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;

    assign marker_o = {~acc_q, ~AM_M[LANE][2], ~AM_M[LANE][1], ~AM_M[LANE][0],
                        acc_q,  AM_M[LANE][2],  AM_M[LANE][1],  AM_M[LANE][0],
                        SYNC_CTRL};

    // A marker restarts the period with its own contribution rather than zero.
    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = bip_fold(marker_o);
        end else if (fold_i) begin
            acc_d = acc_q ^ bip_fold(block_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/am_insert_tx.sv
// Alignment-marker inserter: passes scrambled blocks through and, every AM_GAP
// accepted blocks, stalls upstream for one cycle to emit markers on all lanes.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_AM   | upstream stalled; marker goes out on the next cycle
//   ST_DATA | blocks accepted and forwarded; counts toward the next marker
module am_insert_tx
    import am_tx_pkg::*;
#(
    parameter int LANE_N  = 4,
    parameter int BLOCK_W = 66,
    parameter int AM_GAP  = 16383,
    parameter int CNT_W   = $clog2(AM_GAP)
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        valid_i,
    input  logic [LANE_N*BLOCK_W-1:0]   data_i,
    output logic                        ready_o,
    output logic                        valid_o,
    output logic                        am_v_o,
    output logic [LANE_N*BLOCK_W-1:0]   data_o
);

    if (LANE_N != AM_LANE_N || BLOCK_W != AM_BLOCK_W) begin : g_bad_geometry
        $error("am_insert_tx supports only 4 lanes of 66-bit blocks");
    end
    if (AM_GAP < 2) begin : g_bad_gap
        $error("am_insert_tx needs AM_GAP >= 2");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_GAP - 1);

    am_state_e                    state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         valid_q, valid_d;
    logic                         am_v_q, am_v_d;
    logic [LANE_N*BLOCK_W-1:0]    data_q, data_d;
    logic [LANE_N*BLOCK_W-1:0]    marker_all;
    logic                         load_am;
    logic                         fold_data;

    assign load_am   = (state_q == ST_AM);
    assign fold_data = (state_q == ST_DATA) && valid_i;

    for (genvar l = 0; l < LANE_N; l++) begin : g_lane
        am_bip_lane_tx #(.LANE(l)) u_bip (
            .clk      (clk),
            .nreset   (nreset),
            .block_i  (data_i[l*BLOCK_W +: BLOCK_W]),
            .fold_i   (fold_data),
            .load_i   (load_am),
            .marker_o (marker_all[l*BLOCK_W +: BLOCK_W])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        am_v_d  = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            ST_AM: begin
                valid_d = 1'b1;
                am_v_d  = 1'b1;
                data_d  = marker_all;
                cnt_d   = '0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                valid_d = valid_i;
                if (valid_i) begin
                    data_d = data_i;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_AM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_AM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= ST_AM;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            am_v_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            am_v_q  <= am_v_d;
            data_q  <= data_d;
        end
    end

    assign ready_o = (state_q == ST_DATA);
    assign valid_o = valid_q;
    assign am_v_o  = am_v_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_am_insert_tx.sv
// Directed bench for am_insert_tx with a 4-block marker gap.
module tb_am_insert_tx;

    localparam int LN  = 4;
    localparam int BW  = 66;
    localparam int GAP = 4;
    localparam int DW  = LN * BW;

    logic          clk = 1'b0;
    logic          nreset;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic          valid_o;
    logic          am_v_o;
    logic [DW-1:0] data_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] mtab [0:3][0:2] = '{
        '{8'h90, 8'h76, 8'h47},
        '{8'hF0, 8'hC4, 8'hE6},
        '{8'hC5, 8'h65, 8'h9B},
        '{8'hA2, 8'h79, 8'h3D}
    };

    always #5 clk = ~clk;

    am_insert_tx #(
        .LANE_N  (LN),
        .BLOCK_W (BW),
        .AM_GAP  (GAP)
    ) dut (
        .clk     (clk),
        .nreset  (nreset),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .am_v_o  (am_v_o),
        .data_o  (data_o)
    );

    function automatic logic [BW-1:0] mk_marker(input int lane, input logic [7:0] bip);
        return {~bip, ~mtab[lane][2], ~mtab[lane][1], ~mtab[lane][0],
                 bip,  mtab[lane][2],  mtab[lane][1],  mtab[lane][0], 2'b01};
    endfunction

    function automatic logic [DW-1:0] mk_all(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
        logic [DW-1:0] r;
        r[0*BW +: BW] = mk_marker(0, b0);
        r[1*BW +: BW] = mk_marker(1, b1);
        r[2*BW +: BW] = mk_marker(2, b2);
        r[3*BW +: BW] = mk_marker(3, b3);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] zall;
    logic [DW-1:0] junk;
    logic [DW-1:0] blk;
    logic [65:0]   lane0_exp;
    logic [6:0]    gap_pat;
    int            nlow;

    initial begin
        zall      = {4{64'h0, 2'b10}};
        junk      = {4{64'hDEADBEEF01234567, 2'b11}};
        lane0_exp = {8'hFF, 8'hB8, 8'h89, 8'h6F, 8'h00, 8'h47, 8'h76, 8'h90, 2'b01};
        gap_pat   = 7'b1011001;   // bit k is valid_i on gap step k: 1,0,0,1,1,0,1
        nlow      = 0;

        nreset  = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        step;
        step;
        chk("rst_valid", DW'(valid_o), '0);
        chk("rst_am", DW'(am_v_o), '0);
        chk("rst_data", data_o, '0);
        chk("rst_ready", DW'(ready_o), '0);

        nreset = 1'b1;
        #1;
        chk("am_state_ready", DW'(ready_o), '0);
        step;
        chk("first_valid", DW'(valid_o), DW'(1'b1));
        chk("first_am", DW'(am_v_o), DW'(1'b1));
        chk("first_lane0", DW'(data_o[65:0]), DW'(lane0_exp));
        chk("first_all", data_o, mk_all(8'h00, 8'h00, 8'h00, 8'h00));
        chk("first_ready", DW'(ready_o), DW'(1'b1));

        // continuous zero payload: 4 data blocks then one marker, repeating
        valid_i = 1'b1;
        data_i  = zall;
        for (int k = 0; k < 15; k++) begin
            step;
            chk("run_valid", DW'(valid_o), DW'(1'b1));
            chk("run_am", DW'(am_v_o), DW'((k % 5) == 4));
            chk("run_data", data_o, ((k % 5) == 4) ? mk_all(8'h08, 8'h08, 8'h08, 8'h08) : zall);
            chk("run_ready", DW'(ready_o), DW'((k % 5) != 3));
            if (!ready_o) nlow++;
        end
        chk("ready_low_count", DW'(nlow), DW'(3));

        // gapped valid; junk on idle cycles must not reach BIP or data_o
        for (int k = 0; k < 7; k++) begin
            valid_i = gap_pat[k];
            data_i  = gap_pat[k] ? zall : junk;
            step;
            chk("gap_valid", DW'(valid_o), DW'(gap_pat[k]));
            chk("gap_am", DW'(am_v_o), '0);
            chk("gap_data", data_o, zall);
        end
        chk("gap_am_ready", DW'(ready_o), '0);
        valid_i = 1'b0;
        data_i  = junk;
        step;
        chk("gap_marker_am", DW'(am_v_o), DW'(1'b1));
        chk("gap_marker", data_o, mk_all(8'h08, 8'h08, 8'h08, 8'h08));

        // one block with payload bit 0 (block bit 2) set on lane 2
        for (int k = 0; k < 4; k++) begin
            valid_i = 1'b1;
            blk     = zall;
            if (k == 0) blk[2*BW + 2] = 1'b1;
            data_i  = blk;
            step;
            chk("bit_data", data_o, blk);
        end
        data_i = zall;
        step;
        chk("bit_marker", data_o, mk_all(8'h08, 8'h08, 8'h09, 8'h08));
        chk("bit_lane2_bip3", DW'(data_o[2*BW + 33 -: 8]), DW'(8'h09));

        // reset in the middle of a period
        valid_i = 1'b1;
        data_i  = zall;
        step;
        step;
        chk("pre_rst_am", DW'(am_v_o), '0);
        nreset = 1'b0;
        data_i = junk;
        step;
        chk("mid_rst_valid", DW'(valid_o), '0);
        chk("mid_rst_am", DW'(am_v_o), '0);
        chk("mid_rst_data", data_o, '0);
        chk("mid_rst_ready", DW'(ready_o), '0);
        nreset = 1'b1;
        data_i = zall;
        step;
        chk("post_rst_am", DW'(am_v_o), DW'(1'b1));
        chk("post_rst_marker", data_o, mk_all(8'h00, 8'h00, 8'h00, 8'h00));
        for (int k = 0; k < 5; k++) begin
            step;
            chk("post_rst_seq_am", DW'(am_v_o), DW'(k == 4));
        end
        chk("post_rst_marker2", data_o, mk_all(8'h08, 8'h08, 8'h08, 8'h08));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
